// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
// Two-road intersection controller. A single state register sequences the
// main and auxiliary lights through green, yellow and all-red clearance
// phases. The phase countdown advances only on the external tick strobe.
// A latched pedestrian request trims the main green. Night mode flashes
// yellow on both roads. All outputs are decoded from registered state, so
// a conflicting green pair cannot be produced.
//
// Parameter constraints: every duration lies in 1..2^W-1 and T_PED <= T_MG.

module traffic_light_ctrl #(
    parameter int W     = 5,
    parameter int T_MG  = 15,
    parameter int T_MY  = 3,
    parameter int T_AR  = 2,
    parameter int T_AG  = 7,
    parameter int T_AY  = 3,
    parameter int T_PED = 5
) (
    input  logic         clk,
    input  logic         RST,
    input  logic         tick,
    input  logic         ped_req,
    input  logic         night,
    output logic [2:0]   light_main,
    output logic [2:0]   light_aux,
    output logic         walk,
    output logic [W-1:0] remain,
    output logic [2:0]   phase
);

    // Phase codes are visible on the phase output, so they are fixed.
    typedef enum logic [2:0] {
        ST_MG    = 3'd0,
        ST_MY    = 3'd1,
        ST_AR1   = 3'd2,
        ST_AG    = 3'd3,
        ST_AY    = 3'd4,
        ST_AR2   = 3'd5,
        ST_NIGHT = 3'd6
    } state_t;

    // Durations resized once to the countdown width.
    localparam logic [W-1:0] DUR_MG  = W'(T_MG);
    localparam logic [W-1:0] DUR_MY  = W'(T_MY);
    localparam logic [W-1:0] DUR_AR  = W'(T_AR);
    localparam logic [W-1:0] DUR_AG  = W'(T_AG);
    localparam logic [W-1:0] DUR_AY  = W'(T_AY);
    localparam logic [W-1:0] DUR_PED = W'(T_PED);
    localparam logic [W-1:0] CNT_ONE = W'(1);

    // Lamp encodings, {G,Y,R}.
    localparam logic [2:0] LAMP_G   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           ped_pend_q, ped_pend_d;
    logic           blink_q, blink_d;

    // Last tick of the current phase; every phase transition except the
    // night exit happens on this condition.
    logic           phaseEnd;
    // Pedestrian request seen either from the latch or in this very cycle.
    logic           pedActive;

    assign phaseEnd  = tick && (cnt_q == CNT_ONE);
    assign pedActive = ped_pend_q || ped_req;

    // State register: reset lands in main green with a full count.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= ST_MG;
            cnt_q      <= DUR_MG;
            ped_pend_q <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
            blink_q    <= blink_d;
        end
    end

    // Next-state logic: phase sequencing, countdown, pedestrian latch and
    // night-mode blink.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ped_pend_d = ped_pend_q;
        blink_d    = blink_q;

        // The button is remembered everywhere except while dark; entries
        // into AG or NIGHT below override this and clear the latch.
        if (ped_req && (state_q != ST_NIGHT)) begin
            ped_pend_d = 1'b1;
        end

        case (state_q)
            ST_MG: begin
                if (phaseEnd) begin
                    state_d = ST_MY;
                    cnt_d   = DUR_MY;
                end else if (tick && pedActive && (cnt_q > DUR_PED)) begin
                    cnt_d = DUR_PED;
                end else if (tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_MY: begin
                if (phaseEnd) begin
                    state_d = ST_AR1;
                    cnt_d   = DUR_AR;
                end else if (tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_AR1: begin
                if (phaseEnd) begin
                    ped_pend_d = 1'b0;
                    if (night) begin
                        state_d = ST_NIGHT;
                        cnt_d   = CNT_ONE;
                        blink_d = 1'b0;
                    end else begin
                        state_d = ST_AG;
                        cnt_d   = DUR_AG;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_AG: begin
                if (phaseEnd) begin
                    state_d = ST_AY;
                    cnt_d   = DUR_AY;
                end else if (tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_AY: begin
                if (phaseEnd) begin
                    state_d = ST_AR2;
                    cnt_d   = DUR_AR;
                end else if (tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_AR2: begin
                if (phaseEnd) begin
                    if (night) begin
                        state_d    = ST_NIGHT;
                        cnt_d      = CNT_ONE;
                        blink_d    = 1'b0;
                        ped_pend_d = 1'b0;
                    end else begin
                        state_d = ST_MG;
                        cnt_d   = DUR_MG;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_NIGHT: begin
                // The count is parked at 1 while dark; leaving goes through
                // a full clearance so both roads see red before main green.
                if (tick) begin
                    blink_d = ~blink_q;
                    if (!night) begin
                        state_d = ST_AR2;
                        cnt_d   = DUR_AR;
                    end
                end
            end

            default: begin
                state_d    = ST_MG;
                cnt_d      = DUR_MG;
                ped_pend_d = 1'b0;
                blink_d    = 1'b0;
            end
        endcase
    end

    // Output decode: lamps, walk, countdown and phase code from registers only.
    always_comb begin
        light_main = LAMP_R;
        light_aux  = LAMP_R;
        walk       = 1'b0;
        remain     = cnt_q;
        phase      = state_q;

        case (state_q)
            ST_MG: begin
                light_main = LAMP_G;
                light_aux  = LAMP_R;
            end
            ST_MY: begin
                light_main = LAMP_Y;
                light_aux  = LAMP_R;
            end
            ST_AR1, ST_AR2: begin
                light_main = LAMP_R;
                light_aux  = LAMP_R;
            end
            ST_AG: begin
                light_main = LAMP_R;
                light_aux  = LAMP_G;
                walk       = 1'b1;
            end
            ST_AY: begin
                light_main = LAMP_R;
                light_aux  = LAMP_Y;
            end
            ST_NIGHT: begin
                light_main = blink_q ? LAMP_OFF : LAMP_Y;
                light_aux  = blink_q ? LAMP_OFF : LAMP_Y;
            end
            default: begin
                light_main = LAMP_R;
                light_aux  = LAMP_R;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl
// Directed bench for traffic_light_ctrl. Two instances share the stimulus:
// dutA uses the default parameters, dutB a short-cycle set in which the
// pedestrian shortening can never apply and clearance lasts one tick.

module tb_traffic_light_ctrl;

    logic       clk;
    logic       RST;
    logic       tick;
    logic       ped_req;
    logic       night;

    logic [2:0] mainA, auxA, phaseA;
    logic       walkA;
    logic [4:0] remainA;

    logic [2:0] mainB, auxB, phaseB;
    logic       walkB;
    logic [3:0] remainB;

    int vectors     = 0;
    int miscompares = 0;

    int durA [6] = '{15, 3, 2, 7, 3, 2};
    int durB [6] = '{9, 3, 1, 7, 3, 1};

    traffic_light_ctrl dutA (
        .clk        (clk),
        .RST        (RST),
        .tick       (tick),
        .ped_req    (ped_req),
        .night      (night),
        .light_main (mainA),
        .light_aux  (auxA),
        .walk       (walkA),
        .remain     (remainA),
        .phase      (phaseA)
    );

    traffic_light_ctrl #(
        .W     (4),
        .T_MG  (9),
        .T_MY  (3),
        .T_AR  (1),
        .T_AG  (7),
        .T_AY  (3),
        .T_PED (9)
    ) dutB (
        .clk        (clk),
        .RST        (RST),
        .tick       (tick),
        .ped_req    (ped_req),
        .night      (night),
        .light_main (mainB),
        .light_aux  (auxB),
        .walk       (walkB),
        .remain     (remainB),
        .phase      (phaseB)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs and returns just after the rising edge.
    task automatic applyStimulus(input logic r, input logic t,
                                 input logic p, input logic n);
        RST     = r;
        tick    = t;
        ped_req = p;
        night   = n;
        @(posedge clk);
        #1;
    endtask

    // n consecutive ticks with the given pedestrian and night levels.
    task automatic tickN(input int n, input logic p, input logic nt);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, p, nt);
    endtask

    // Expected phase and remaining count after s ticks from the MG start,
    // walking the nominal sequence of durations.
    function automatic void model(input int s, input int d [6],
                                  output int ph, output int rem);
        int total;
        int acc;
        total = 0;
        for (int i = 0; i < 6; i++) total += d[i];
        s   = s % total;
        acc = 0;
        ph  = 0;
        rem = 0;
        for (int i = 0; i < 6; i++) begin
            if ((rem == 0) && (s < acc + d[i])) begin
                ph  = i;
                rem = acc + d[i] - s;
            end
            acc += d[i];
        end
    endfunction

    // Lamp patterns per phase code, {G,Y,R}.
    function automatic logic [2:0] mainOf(input int ph);
        case (ph)
            0:       return 3'b100;
            1:       return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [2:0] auxOf(input int ph);
        case (ph)
            3:       return 3'b100;
            4:       return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    task automatic checkA(input int ph, input int rem);
        checkOutput("A.phase", phaseA, ph);
        checkOutput("A.remain", remainA, rem);
        checkOutput("A.main", mainA, mainOf(ph));
        checkOutput("A.aux", auxA, auxOf(ph));
        checkOutput("A.walk", walkA, (ph == 3) ? 1 : 0);
    endtask

    task automatic checkResetA();
        checkOutput("rst.main", mainA, 3'b100);
        checkOutput("rst.aux", auxA, 3'b001);
        checkOutput("rst.walk", walkA, 0);
        checkOutput("rst.remain", remainA, 15);
        checkOutput("rst.phase", phaseA, 0);
    endtask

    initial begin
        int ph;
        int rem;

        RST     = 1'b0;
        tick    = 1'b0;
        ped_req = 1'b0;
        night   = 1'b0;

        // Reset values, then one full period with a tick every cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkResetA();
        for (int s = 1; s <= 32; s++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            model(s, durA, ph, rem);
            checkA(ph, rem);
            checkOutput("A.noDoubleGreen", mainA[2] & auxA[2], 0);
        end
        checkOutput("A.periodPhase", phaseA, 0);
        checkOutput("A.periodRemain", remainA, 15);

        // Tick every 4th cycle: MG holds 60 cycles.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 60; c++) begin
            applyStimulus(1'b0, (c % 4) == 0, 1'b0, 1'b0);
            if (c < 60) begin
                checkOutput("slow.phase", phaseA, 0);
                checkOutput("slow.remain", remainA, 15 - c / 4);
            end else begin
                checkOutput("slow.endPhase", phaseA, 1);
                checkOutput("slow.endRemain", remainA, 3);
            end
        end

        // Pedestrian request latched without a tick, applied on the next tick.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tickN(3, 1'b0, 1'b0);
        checkOutput("ped.at12", remainA, 12);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("ped.noTickHold", remainA, 12);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("ped.shortened", remainA, 5);
        tickN(4, 1'b0, 1'b0);
        checkA(0, 1);
        tickN(1, 1'b0, 1'b0);
        checkA(1, 3);
        tickN(5, 1'b0, 1'b0);
        checkA(3, 7);
        tickN(12, 1'b0, 1'b0);
        checkA(0, 15);
        tickN(1, 1'b0, 1'b0);
        checkOutput("ped.clearedAtAG", remainA, 14);
        tickN(11, 1'b0, 1'b0);
        checkOutput("ped.at3", remainA, 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("ped.lateNoEffect", remainA, 2);
        tickN(2, 1'b0, 1'b0);
        checkA(1, 3);

        // Same-cycle request with a tick counts immediately.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("ped.sameCycle", remainA, 5);

        // Night raised during AG: AY and AR2 run out, then flashing yellow.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tickN(20, 1'b0, 1'b0);
        checkA(3, 7);
        tickN(7, 1'b0, 1'b1);
        checkA(4, 3);
        tickN(3, 1'b0, 1'b1);
        checkA(5, 2);
        tickN(2, 1'b0, 1'b1);
        checkOutput("night.phase", phaseA, 6);
        checkOutput("night.remain", remainA, 1);
        checkOutput("night.main0", mainA, 3'b010);
        checkOutput("night.aux0", auxA, 3'b010);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("night.noTickHold", mainA, 3'b010);
        tickN(1, 1'b0, 1'b1);
        checkOutput("night.main1", mainA, 3'b000);
        checkOutput("night.aux1", auxA, 3'b000);
        tickN(1, 1'b0, 1'b1);
        checkOutput("night.main2", mainA, 3'b010);
        checkOutput("night.aux2", auxA, 3'b010);
        tickN(1, 1'b0, 1'b0);
        checkA(5, 2);
        tickN(2, 1'b0, 1'b0);
        checkA(0, 15);

        // Reset mid-AY overrides every other input; no request is retained.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tickN(27, 1'b0, 1'b0);
        checkA(4, 3);
        tickN(1, 1'b0, 1'b0);
        checkOutput("rstAY.before", remainA, 2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkResetA();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rstAY.noPedPend", remainA, 14);

        // Night entered from AR1, then reset while dark.
        tickN(19, 1'b0, 1'b1);
        checkOutput("rstNight.inNight", phaseA, 6);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkResetA();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rstNight.after", remainA, 14);

        // Alternate parameters: request held high never shortens MG.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("B.rstPhase", phaseB, 0);
        checkOutput("B.rstRemain", remainB, 9);
        for (int s = 1; s <= 24; s++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
            model(s, durB, ph, rem);
            checkOutput("B.phase", phaseB, ph);
            checkOutput("B.remain", remainB, rem);
            checkOutput("B.main", mainB, mainOf(ph));
            checkOutput("B.aux", auxB, auxOf(ph));
            checkOutput("B.walk", walkB, (ph == 3) ? 1 : 0);
        end
        checkOutput("B.periodPhase", phaseB, 0);
        checkOutput("B.periodRemain", remainB, 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
